// File: rtl/cout_capture_fifo.sv
// ---------------------------------------------------------------------------
// cout_capture_fifo
//
// Watches the output of the 8-bit loadable counter and stores snapshots of it
// in a small first-word-fall-through FIFO. A snapshot is taken on an explicit
// capture strobe, or automatically when the counter wraps from all-ones to
// zero by incrementing (when WRAP_CAPTURE is set). The host drains the FIFO
// through a valid/ready read port.
//
// Ports
//   clk       in   clock, all state on the rising edge
//   reset     in   synchronous, active-high reset
//   cout      in   counter value being observed
//   enable    in   counter enable (same net that drives the counter)
//   load      in   counter load (same net that drives the counter)
//   capture   in   explicit snapshot request
//   rd_ready  in   consumer accepts the head entry
//   rd_valid  out  FIFO holds at least one entry
//   rd_data   out  head snapshot, 0 when empty
//   rd_tag    out  head origin: 1 = wrap event, 0 = capture only; 0 when empty
//   level     out  number of stored entries, 0..DEPTH
//   overflow  out  sticky flag: a push was dropped because the FIFO was full
//   clr_ovf   in   clears overflow (a drop in the same cycle wins)
// ---------------------------------------------------------------------------
module cout_capture_fifo #(
    parameter int WIDTH        = 8,
    parameter int DEPTH        = 4,
    parameter int WRAP_CAPTURE = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           cout,
    input  logic                       enable,
    input  logic                       load,
    input  logic                       capture,
    input  logic                       rd_ready,
    output logic                       rd_valid,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       rd_tag,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    input  logic                       clr_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0]    LVL_ONE  = {{(LW-1){1'b0}}, 1'b1};
    localparam logic [LW-1:0]    LVL_ZERO = {LW{1'b0}};
    localparam logic [LW-1:0]    LVL_FULL = LW'(DEPTH);
    localparam logic [AW-1:0]    PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] CNT_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};

    logic [WIDTH-1:0] cout_q_r;
    logic             inc_q_r;
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [LW-1:0]    level_r;
    logic             overflow_r;
    logic [WIDTH-1:0] mem_data_r [DEPTH];
    logic             mem_tag_r  [DEPTH];

    logic             wrap_evt_s;
    logic             push_req_s;
    logic             pop_s;
    logic             full_s;
    logic             push_ok_s;
    logic             drop_s;
    logic [LW-1:0]    level_nxt_s;

    // Event detection and push/pop arbitration for this cycle.
    always_comb begin
        wrap_evt_s  = 1'b0;
        push_req_s  = 1'b0;
        pop_s       = 1'b0;
        full_s      = 1'b0;
        push_ok_s   = 1'b0;
        drop_s      = 1'b0;
        level_nxt_s = level_r;
        // A wrap needs an increment at the previous edge; a load of 0 from
        // all-ones has inc_q_r low and is therefore not a wrap.
        if (WRAP_CAPTURE != 0) begin
            wrap_evt_s = inc_q_r && (cout_q_r == CNT_ONES) && (cout == CNT_ZERO);
        end else begin
            wrap_evt_s = 1'b0;
        end
        push_req_s = capture || wrap_evt_s;
        pop_s      = (level_r != LVL_ZERO) && rd_ready;
        full_s     = (level_r == LVL_FULL);
        // When full, a simultaneous pop frees the slot being written.
        push_ok_s  = push_req_s && (!full_s || pop_s);
        drop_s     = push_req_s && full_s && !pop_s;
        if (push_ok_s && !pop_s) begin
            level_nxt_s = level_r + LVL_ONE;
        end else if (pop_s && !push_ok_s) begin
            level_nxt_s = level_r - LVL_ONE;
        end else begin
            level_nxt_s = level_r;
        end
    end

    // Counter history, pointers, level and sticky overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            cout_q_r   <= CNT_ZERO;
            inc_q_r    <= 1'b0;
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            level_r    <= LVL_ZERO;
            overflow_r <= 1'b0;
        end else begin
            cout_q_r <= cout;
            inc_q_r  <= enable && !load;
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            level_r <= level_nxt_s;
            // Set has priority over clear.
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (clr_ovf) begin
                overflow_r <= 1'b0;
            end
        end
    end

    // Storage array; contents are only visible through the valid-gated head.
    always_ff @(posedge clk) begin
        if (push_ok_s && !reset) begin
            mem_data_r[wr_ptr_r] <= cout;
            mem_tag_r[wr_ptr_r]  <= wrap_evt_s;
        end
    end

    assign rd_valid = (level_r != LVL_ZERO);
    assign rd_data  = rd_valid ? mem_data_r[rd_ptr_r] : CNT_ZERO;
    assign rd_tag   = rd_valid ? mem_tag_r[rd_ptr_r] : 1'b0;
    assign level    = level_r;
    assign overflow = overflow_r;

endmodule

// File: tb/tb_cout_capture_fifo.sv
module tb_cout_capture_fifo;

    localparam int DEPTH = 4;

    logic       clk;
    logic       reset_t;
    logic [7:0] cnt;
    logic [7:0] load_val;
    logic       enable_t;
    logic       load_t;
    logic       capture_t;
    logic       rd_ready_t;
    logic       clr_ovf_t;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       rd_tag;
    logic [2:0] level;
    logic       overflow;

    int n_vec;
    int n_err;

    // scoreboard: {tag, data}
    logic [8:0] sb_q [$];
    logic       m_ovf;
    logic [7:0] m_prev;
    logic       m_inc;

    cout_capture_fifo #(.WIDTH(8), .DEPTH(DEPTH), .WRAP_CAPTURE(1)) dut (
        .clk      (clk),
        .reset    (reset_t),
        .cout     (cnt),
        .enable   (enable_t),
        .load     (load_t),
        .capture  (capture_t),
        .rd_ready (rd_ready_t),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .rd_tag   (rd_tag),
        .level    (level),
        .overflow (overflow),
        .clr_ovf  (clr_ovf_t)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: update the reference model from the current inputs,
    // check any pop against the scoreboard, advance the clock, model the
    // upstream counter and check the registered state.
    task automatic cyc();
        logic       wrap;
        logic       push;
        logic       drop;
        logic [8:0] hd;
        wrap = 1'b0;
        drop = 1'b0;
        if (reset_t) begin
            sb_q.delete();
            m_ovf = 1'b0;
        end else begin
            wrap = m_inc && (m_prev == 8'hFF) && (cnt == 8'h00);
            if (rd_ready_t && (sb_q.size() > 0)) begin
                hd = sb_q.pop_front();
                check("pop_data", {24'h0, rd_data}, {24'h0, hd[7:0]});
                check("pop_tag", {31'h0, rd_tag}, {31'h0, hd[8]});
            end
            push = capture_t || wrap;
            if (push) begin
                if (sb_q.size() < DEPTH) sb_q.push_back({wrap, cnt});
                else drop = 1'b1;
            end
            m_ovf = (m_ovf && !clr_ovf_t) || drop;
        end
        m_prev = reset_t ? 8'h00 : cnt;
        m_inc  = reset_t ? 1'b0 : (enable_t && !load_t);
        @(posedge clk);
        #1;
        if (load_t) cnt = load_val;
        else if (enable_t) cnt = cnt + 8'd1;
        check("level", {29'h0, level}, sb_q.size());
        check("rd_valid", {31'h0, rd_valid}, {31'h0, (sb_q.size() != 0)});
        check("overflow", {31'h0, overflow}, {31'h0, m_ovf});
        if (sb_q.size() == 0) begin
            check("empty_data", {24'h0, rd_data}, 32'h0);
            check("empty_tag", {31'h0, rd_tag}, 32'h0);
        end
    endtask

    task automatic idle_inputs();
        enable_t = 1'b0; load_t = 1'b0; capture_t = 1'b0;
        rd_ready_t = 1'b0; clr_ovf_t = 1'b0;
    endtask

    task automatic drain(input int n);
        rd_ready_t = 1'b1;
        for (int i = 0; i < n; i++) cyc();
        rd_ready_t = 1'b0;
    endtask

    task automatic load_cnt(input logic [7:0] v);
        load_t = 1'b1; load_val = v;
        cyc();
        load_t = 1'b0;
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        m_ovf = 1'b0; m_prev = 8'h00; m_inc = 1'b0;
        cnt = 8'h00; load_val = 8'h00;
        idle_inputs();
        reset_t = 1'b1;
        cyc(); cyc();
        reset_t = 1'b0;

        // 1: idle after reset
        for (int i = 0; i < 10; i++) cyc();

        // 2: explicit capture, single pop
        load_cnt(8'h3C);
        capture_t = 1'b1; cyc(); capture_t = 1'b0;
        check("t2_data", {24'h0, rd_data}, 32'h3C);
        check("t2_tag", {31'h0, rd_tag}, 32'h0);
        drain(1);
        check("t2_level", {29'h0, level}, 32'd0);

        // 3: wrap by increment creates one tagged entry
        load_cnt(8'hFE);
        enable_t = 1'b1;
        cyc(); cyc(); cyc();
        enable_t = 1'b0;
        check("t3_level", {29'h0, level}, 32'd1);
        check("t3_data", {24'h0, rd_data}, 32'h00);
        check("t3_tag", {31'h0, rd_tag}, 32'h1);
        drain(1);
        // load of 0 from FF is not a wrap
        load_cnt(8'hFE);
        enable_t = 1'b1; cyc();
        load_t = 1'b1; load_val = 8'h00; cyc();
        load_t = 1'b0; enable_t = 1'b0;
        cyc(); cyc();
        check("t3_noload_wrap", {29'h0, level}, 32'd0);

        // 4: overfill, drain order, clear overflow
        load_cnt(8'h01);
        enable_t = 1'b1; capture_t = 1'b1;
        for (int i = 0; i < 5; i++) cyc();
        enable_t = 1'b0; capture_t = 1'b0;
        check("t4_level", {29'h0, level}, 32'd4);
        check("t4_ovf", {31'h0, overflow}, 32'h1);
        drain(4);
        clr_ovf_t = 1'b1; cyc(); clr_ovf_t = 1'b0;
        check("t4_clr", {31'h0, overflow}, 32'h0);

        // 5: full, push with simultaneous pop
        load_cnt(8'h10);
        enable_t = 1'b1; capture_t = 1'b1;
        for (int i = 0; i < 4; i++) cyc();
        rd_ready_t = 1'b1; cyc();
        enable_t = 1'b0; capture_t = 1'b0; rd_ready_t = 1'b0;
        check("t5_level", {29'h0, level}, 32'd4);
        check("t5_ovf", {31'h0, overflow}, 32'h0);
        drain(4);

        // drop and clear in the same cycle: set wins
        capture_t = 1'b1;
        for (int i = 0; i < 4; i++) cyc();
        clr_ovf_t = 1'b1; cyc();
        capture_t = 1'b0; clr_ovf_t = 1'b0;
        check("t5_setwins", {31'h0, overflow}, 32'h1);
        // empty + push + ready: entry kept
        drain(4);
        clr_ovf_t = 1'b1; cyc(); clr_ovf_t = 1'b0;
        capture_t = 1'b1; rd_ready_t = 1'b1; cyc();
        capture_t = 1'b0; rd_ready_t = 1'b0;
        check("t5_empty_push", {29'h0, level}, 32'd1);
        drain(1);

        // 6: capture coincident with wrap -> one tagged entry
        load_cnt(8'hFF);
        enable_t = 1'b1; cyc();
        enable_t = 1'b0; capture_t = 1'b1; cyc();
        capture_t = 1'b0;
        check("t6_single", {29'h0, level}, 32'd1);
        check("t6_tag", {31'h0, rd_tag}, 32'h1);
        capture_t = 1'b1; cyc(); cyc(); capture_t = 1'b0;
        check("t6_level3", {29'h0, level}, 32'd3);
        reset_t = 1'b1; cyc(); reset_t = 1'b0;
        check("t6_rst_level", {29'h0, level}, 32'd0);
        check("t6_rst_valid", {31'h0, rd_valid}, 32'h0);
        cyc(); cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
